// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// Block-move / fill engine sitting in front of a single-port data memory
// (combinational read, synchronous write). While idle, the CPU's address,
// write enable and write data pass straight through to the memory. Once a
// Start is accepted, the engine owns the port and either copies Len bytes
// from Src to Dst (one read cycle plus one write cycle per byte) or fills
// Len bytes at Dst with FillVal (one write cycle per byte). Pointers step
// up or down according to Dir and wrap modulo 2^AW.
//
// Ports
//   Clk, ResetN            clock (rising edge), async active-low reset
//   Start                  request pulse, sampled only in IDLE
//   Mode, Dir              0/1 = copy/fill, ascending/descending
//   Src, Dst, Len, FillVal transfer description, latched on accepted Start
//   Busy, Done, Remaining  engine status
//   CpuAddr/WrEn/WrData    CPU side of the memory port
//   CpuRdData, CpuStall    read data back to the CPU, stall while Busy
//   MemAddr/WrEn/WrData    memory side of the port
//   MemRdData              combinational read data of MemAddr
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          Start,
    input  logic          Mode,
    input  logic          Dir,
    input  logic [AW-1:0] Src,
    input  logic [AW-1:0] Dst,
    input  logic [AW-1:0] Len,
    input  logic [DW-1:0] FillVal,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] Remaining,
    input  logic [AW-1:0] CpuAddr,
    input  logic          CpuWrEn,
    input  logic [DW-1:0] CpuWrData,
    output logic [DW-1:0] CpuRdData,
    output logic          CpuStall,
    output logic [AW-1:0] MemAddr,
    output logic          MemWrEn,
    output logic [DW-1:0] MemWrData,
    input  logic [DW-1:0] MemRdData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          dir_q, dir_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [DW-1:0] rd_buf_q, rd_buf_d;
    logic [DW-1:0] fill_val_q, fill_val_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] step;

    // All-ones is -1 modulo 2^AW, so one adder serves both directions.
    assign step = dir_q ? '1 : AW'(1);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        rd_buf_d    = rd_buf_q;
        fill_val_d  = fill_val_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    mode_d      = Mode;
                    dir_d       = Dir;
                    src_ptr_d   = Src;
                    dst_ptr_d   = Dst;
                    remaining_d = Len;
                    fill_val_d  = FillVal;
                    if (Len == '0)
                        state_d = DONE;
                    else if (Mode)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                rd_buf_d = MemRdData;
                state_d  = WRITE;
            end
            WRITE: begin
                src_ptr_d   = src_ptr_q + step;
                dst_ptr_d   = dst_ptr_q + step;
                remaining_d = remaining_q - AW'(1);
                if (remaining_q == AW'(1))
                    state_d = DONE;
                else if (mode_q)
                    state_d = WRITE;
                else
                    state_d = READ;
            end
            DONE: begin
                // Any Start seen here is dropped, not queued.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d == READ) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            rd_buf_q    <= '0;
            fill_val_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            rd_buf_q    <= rd_buf_d;
            fill_val_q  <= fill_val_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Port mux decodes the state register directly, so an async reset
    // mid-transfer removes the engine's write enable immediately.
    always_comb begin
        MemAddr   = CpuAddr;
        MemWrEn   = CpuWrEn;
        MemWrData = CpuWrData;
        unique case (state_q)
            READ: begin
                MemAddr = src_ptr_q;
                MemWrEn = 1'b0;
            end
            WRITE: begin
                MemAddr   = dst_ptr_q;
                MemWrEn   = 1'b1;
                MemWrData = mode_q ? fill_val_q : rd_buf_q;
            end
            default: begin
            end
        endcase
    end

    assign CpuRdData = MemRdData;
    assign CpuStall  = busy_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Remaining = remaining_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
// Self-checking bench for mem_copy_engine. The bench owns a 256x8 memory
// (combinational read, write on the rising edge) wired to the Mem* ports,
// and keeps a separate reference image that is updated byte by byte from
// the transfer description (src/dst/len/dir/mode). Each transfer is checked
// cycle by cycle (Busy, Done, Remaining, address, write enable, write data)
// and the whole memory is compared afterwards.
module tb_mem_copy_engine;

    logic       Clk = 1'b0;
    logic       ResetN;
    logic       Start, Mode, Dir;
    logic [7:0] Src, Dst, Len, FillVal;
    logic       Busy, Done, CpuStall, MemWrEn, CpuWrEn;
    logic [7:0] Remaining, CpuAddr, CpuWrData, CpuRdData;
    logic [7:0] MemAddr, MemWrData, MemRdData;

    logic [7:0] mem    [256];
    logic [7:0] refMem [256];

    int testsRun  = 0;
    int failCount = 0;

    always #5 Clk = ~Clk;

    // Environment memory: combinational read, synchronous write.
    always @(posedge Clk) begin
        if (MemWrEn) mem[MemAddr] <= MemWrData;
    end
    assign MemRdData = mem[MemAddr];

    mem_copy_engine #(.AW(8), .DW(8)) dut (
        .Clk(Clk), .ResetN(ResetN), .Start(Start), .Mode(Mode), .Dir(Dir),
        .Src(Src), .Dst(Dst), .Len(Len), .FillVal(FillVal),
        .Busy(Busy), .Done(Done), .Remaining(Remaining),
        .CpuAddr(CpuAddr), .CpuWrEn(CpuWrEn), .CpuWrData(CpuWrData),
        .CpuRdData(CpuRdData), .CpuStall(CpuStall),
        .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData),
        .MemRdData(MemRdData)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic preload(input logic [7:0] addr, input logic [7:0] val);
        mem[addr]    = val;
        refMem[addr] = val;
    endtask

    // Compares the full memory against the reference image.
    task automatic compareMem(input string tag);
        int bad = 0;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== refMem[a]) begin
                if (bad == 0)
                    $display("[TB] first difference mem[%02h]=%02h ref=%02h", a, mem[a], refMem[a]);
                bad++;
            end
        end
        checkOutput(tag, 32'(bad), 32'(0));
    endtask

    function automatic logic [7:0] stepAddr(input logic [7:0] base, input logic d, input int k);
        return d ? base - 8'(k) : base + 8'(k);
    endfunction

    // Runs one transfer from a negedge with the engine idle. pokeCpu keeps
    // a CPU write request active while Busy (it must be blocked);
    // extraStart pulses Start mid-transfer and in the Done cycle (ignored).
    task automatic applyStimulus(input logic m, input logic d, input logic [7:0] s,
                                 input logic [7:0] t, input logic [7:0] n,
                                 input logic [7:0] f, input bit pokeCpu,
                                 input bit extraStart);
        int expBusy   = (n == 0) ? 0 : (m ? int'(n) : 2 * int'(n));
        int doneCycle = expBusy + 1;
        int k;
        bit isRead;
        logic [7:0] expAddr, expData, pokeAddr;
        pokeAddr = 8'($urandom_range(0, 255));
        Mode = m; Dir = d; Src = s; Dst = t; Len = n; FillVal = f;
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        for (int c = 1; c <= doneCycle + 3; c++) begin
            Start = extraStart && ((c == 2 && c <= expBusy) || c == doneCycle);
            if (c <= expBusy) begin
                CpuWrEn = pokeCpu; CpuAddr = pokeAddr; CpuWrData = 8'hEE;
                #1;
                k      = m ? c - 1 : (c - 1) / 2;
                isRead = !m && (c % 2 == 1);
                expAddr = isRead ? stepAddr(s, d, k) : stepAddr(t, d, k);
                checkOutput("busy", 32'(Busy), 32'(1));
                checkOutput("stall", 32'(CpuStall), 32'(1));
                checkOutput("done_early", 32'(Done), 32'(0));
                checkOutput("remaining", 32'(Remaining), 32'(int'(n) - k));
                checkOutput("wren", 32'(MemWrEn), 32'(!isRead));
                checkOutput("addr", 32'(MemAddr), 32'(expAddr));
                if (!isRead) begin
                    expData = m ? f : refMem[stepAddr(s, d, k)];
                    checkOutput("wrdata", 32'(MemWrData), 32'(expData));
                    refMem[expAddr] = expData;
                end
            end else begin
                CpuWrEn = 1'b0;
                #1;
                checkOutput("busy_idle", 32'(Busy), 32'(0));
                checkOutput("wren_idle", 32'(MemWrEn), 32'(0));
                checkOutput(c == doneCycle ? "done_pulse" : "done_extra",
                            32'(Done), 32'(c == doneCycle));
                if (c == doneCycle)
                    checkOutput("remaining_end", 32'(Remaining), 32'(0));
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        compareMem("mem_after_transfer");
    endtask

    // Len=8 copy interrupted by reset during its third write cycle.
    task automatic applyResetMidCopy();
        for (int i = 0; i < 8; i++) preload(8'h60 + 8'(i), 8'h30 + 8'(i));
        Mode = 1'b0; Dir = 1'b0; Src = 8'h60; Dst = 8'hA0; Len = 8'd8; Start = 1'b1;
        CpuWrEn = 1'b0; CpuAddr = 8'h05;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        #1;
        checkOutput("rst_third_write_wren", 32'(MemWrEn), 32'(1));
        checkOutput("rst_third_write_addr", 32'(MemAddr), 32'(8'hA2));
        ResetN = 1'b0;
        #1;
        checkOutput("rst_wren_drop", 32'(MemWrEn), 32'(0));
        checkOutput("rst_busy", 32'(Busy), 32'(0));
        checkOutput("rst_remaining", 32'(Remaining), 32'(0));
        checkOutput("rst_done", 32'(Done), 32'(0));
        checkOutput("rst_passthru_addr", 32'(MemAddr), 32'(8'h05));
        refMem[8'hA0] = 8'h30;
        refMem[8'hA1] = 8'h31;
        @(negedge Clk);
        ResetN = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            #1;
            checkOutput("rst_no_done", 32'(Done), 32'(0));
            checkOutput("rst_stays_idle", 32'(Busy), 32'(0));
        end
        compareMem("rst_mem");
    endtask

    initial begin
        ResetN = 1'b0; Start = 1'b0; Mode = 1'b0; Dir = 1'b0;
        Src = '0; Dst = '0; Len = '0; FillVal = '0;
        CpuWrEn = 1'b0; CpuAddr = 8'h33; CpuWrData = '0;
        for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom_range(0, 255)));
        #1;
        checkOutput("reset_busy", 32'(Busy), 32'(0));
        checkOutput("reset_done", 32'(Done), 32'(0));
        checkOutput("reset_remaining", 32'(Remaining), 32'(0));
        checkOutput("reset_passthru_addr", 32'(MemAddr), 32'(8'h33));
        @(negedge Clk);
        ResetN = 1'b1;
        @(negedge Clk);

        $display("[TB] ascending copy");
        preload(8'h10, 8'hA1); preload(8'h11, 8'hB2);
        preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
        applyStimulus(1'b0, 1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 1'b1, 1'b0);
        checkOutput("copy_b0", 32'(mem[8'h80]), 32'(8'hA1));
        checkOutput("copy_b3", 32'(mem[8'h83]), 32'(8'hD4));

        $display("[TB] fill with wrap");
        preload(8'h01, 8'h99);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'hFE, 8'd3, 8'h5A, 1'b1, 1'b0);
        checkOutput("fill_fe", 32'(mem[8'hFE]), 32'(8'h5A));
        checkOutput("fill_00", 32'(mem[8'h00]), 32'(8'h5A));
        checkOutput("fill_01_untouched", 32'(mem[8'h01]), 32'(8'h99));

        $display("[TB] overlapping descending copy");
        preload(8'h20, 8'h01); preload(8'h21, 8'h02);
        preload(8'h22, 8'h03); preload(8'h23, 8'h04);
        applyStimulus(1'b0, 1'b1, 8'h23, 8'h24, 8'd4, 8'h00, 1'b0, 1'b0);
        checkOutput("ovl_21", 32'(mem[8'h21]), 32'(8'h01));
        checkOutput("ovl_22", 32'(mem[8'h22]), 32'(8'h02));
        checkOutput("ovl_23", 32'(mem[8'h23]), 32'(8'h03));
        checkOutput("ovl_24", 32'(mem[8'h24]), 32'(8'h04));

        $display("[TB] zero length");
        applyStimulus(1'b0, 1'b0, 8'h37, 8'hC8, 8'd0, 8'h00, 1'b0, 1'b0);

        $display("[TB] passthrough and ignored start");
        CpuAddr = 8'h40; CpuWrEn = 1'b1; CpuWrData = 8'h77;
        #1;
        checkOutput("pt_addr", 32'(MemAddr), 32'(8'h40));
        checkOutput("pt_wren", 32'(MemWrEn), 32'(1));
        checkOutput("pt_wrdata", 32'(MemWrData), 32'(8'h77));
        @(negedge Clk);
        CpuWrEn = 1'b0;
        refMem[8'h40] = 8'h77;
        #1;
        checkOutput("pt_rddata", 32'(CpuRdData), 32'(8'h77));
        checkOutput("pt_mem", 32'(mem[8'h40]), 32'(8'h77));
        @(negedge Clk);
        applyStimulus(1'b0, 1'b0, 8'h50, 8'h90, 8'd5, 8'h00, 1'b1, 1'b1);

        $display("[TB] reset mid-copy");
        applyResetMidCopy();

        $display("[TB] randomized transfers");
        for (int i = 0; i < 20; i++) begin
            logic m, d;
            logic [7:0] s, t, n, f;
            m = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            s = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            n = (i == 0) ? 8'd255 : 8'($urandom_range(0, 20));
            f = 8'($urandom_range(0, 255));
            applyStimulus(m, d, s, t, n, f, bit'($urandom_range(0, 1)),
                          (n >= 8'd2) && bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Block-move/fill engine that sits directly upstream of the 256x8 data memory and owns its single address/write port. When idle it passes the CPU's memory requests through combinationally. When started, it takes the port and copies a run of bytes from one address to another, or fills a run with a constant. Memory reads are combinational and writes are sequential, so each copied byte takes one read cycle and one write cycle.

Parameters:
AW, 8, address width; memory depth 2^AW, all pointers wrap modulo 2^AW
DW, 8, data width

Ports:
Clk  input  1  clock, rising edge
ResetN  input  1  asynchronous, active-low reset
Start  input  1  request pulse; sampled only in IDLE
Mode  input  1  0 = copy, 1 = fill; latched on accepted Start
Dir  input  1  0 = ascending pointers, 1 = descending; latched on Start
Src  input  AW  copy source start address; latched on Start
Dst  input  AW  destination start address; latched on Start
Len  input  AW  byte count, 0..255; latched on Start
FillVal  input  DW  fill byte; latched on Start
Busy  output  1  engine owns the memory port (states READ/WRITE)
Done  output  1  one-cycle completion pulse
Remaining  output  AW  bytes still to write
CpuAddr  input  AW  CPU address, passed through when not Busy
CpuWrEn  input  1  CPU write enable, passed through when not Busy
CpuWrData  input  DW  CPU write data
CpuRdData  output  DW  equals MemRdData at all times
CpuStall  output  1  equals Busy
MemAddr  output  AW  to memory DataAddress
MemWrEn  output  1  to memory WriteEn
MemWrData  output  DW  to memory DataIn
MemRdData  input  DW  from memory DataOut[7:0]; combinational read of MemAddr

Behaviour:
- Reset (ResetN=0, async): state IDLE; SrcPtr, DstPtr, Remaining, RdBuf, Done all 0; Busy=0. Mem* outputs follow the CPU inputs.
- Reset mid-transfer: MemWrEn from the engine drops immediately with the state change, not at the next edge. Bytes already written stay written. No Done pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE: on a rising edge with Start=1, latch Mode, Dir, Src, Dst, Len, FillVal, and set Remaining=Len. Next state:
  - DONE if Len=0;
  - WRITE if Mode=1;
  - READ otherwise.
- READ: MemAddr=SrcPtr, MemWrEn=0. At the edge, RdBuf<=MemRdData, then go to WRITE.
- WRITE: MemAddr=DstPtr, MemWrEn=1, MemWrData = RdBuf (copy) or FillVal (fill). At the edge:
  - the memory writes;
  - DstPtr and SrcPtr step by +1 (Dir=0) or -1 (Dir=1), modulo 256;
  - Remaining decrements;
  - if Remaining was 1, go to DONE; else go to READ (copy) or stay in WRITE (fill).
- DONE: Done=1 and Busy=0 for exactly one cycle; the CPU regains the port this cycle. Next state is IDLE.
- Start while not in IDLE (including DONE) is ignored, not queued.
- Latency from the accepting edge:
  - copy of N bytes: Busy for 2N cycles, Done in cycle 2N+1;
  - fill: Busy for N cycles, Done in cycle N+1;
  - Len=0: Done in cycle 1, no writes.
- Pointer wrap: ascending past 0xFF continues at 0x00; descending below 0x00 continues at 0xFF.
- Overlapping copies are done byte by byte in the Dir direction. Software picks Dir=1 when Dst>Src and the ranges overlap.
- While Busy, CpuWrEn is blocked from the memory, and CpuRdData shows engine-addressed data. The CPU must honour CpuStall.

Test Plan:
- Copy, ascending: preload mem[0x10..0x13]=A1,B2,C3,D4; Start Mode=0 Dir=0 Src=0x10 Dst=0x80 Len=4 -> mem[0x80..0x83]=A1,B2,C3,D4; Busy 8 cycles; Done in cycle 9; Remaining steps 4..0.
- Fill with wrap: Mode=1 FillVal=5A Dst=0xFE Len=3 -> mem[0xFE], mem[0xFF], mem[0x00]=5A; mem[0x01] unchanged; Busy 3 cycles.
- Overlapping descending copy: mem[0x20..0x23]=01,02,03,04; Dir=1 Src=0x23 Dst=0x24 Len=4 -> mem[0x21..0x24]=01,02,03,04 with no smearing.
- Len=0: Start with any addresses -> MemWrEn never asserted by the engine; Done=1 in the cycle after acceptance; Busy stays 0.
- Passthrough and ignored Start: while idle, CpuWrEn=1 CpuAddr=0x40 CpuWrData=77 -> mem[0x40]=77. A second Start pulsed during Busy -> no second transfer, exactly one Done.
- Reset mid-copy: assert ResetN=0 during the third WRITE of a Len=8 copy -> MemWrEn drops with reset; Busy=0; Remaining=0; no Done. First two destination bytes are written, the rest untouched.
